mc_resp_model: RTL

MC_RESP_MODEL -- requirements
Module: mc_resp_model

---
 rtl/mc_resp_model_if.sv | 36 +++
 rtl/mc_resp_model.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/mc_resp_model_if.sv
// Request/response bundle between a memory-controller requester and mc_resp_model.
// master = requester side, slave = model side.
interface mc_resp_model_if #(
  parameter int unsigned RTNCTL_WIDTH = 32
);
  logic                    mc_rq_vld;
  logic [2:0]              mc_rq_cmd;
  logic [3:0]              mc_rq_scmd;
  logic [1:0]              mc_rq_size;
  logic [47:0]             mc_rq_vadr;
  logic [63:0]             mc_rq_data;
  logic [RTNCTL_WIDTH-1:0] mc_rq_rtnctl;
  logic                    mc_rq_flush;
  logic                    mc_rq_stall;
  logic                    mc_rs_vld;
  logic [2:0]              mc_rs_cmd;
  logic [3:0]              mc_rs_scmd;
  logic [63:0]             mc_rs_data;
  logic [RTNCTL_WIDTH-1:0] mc_rs_rtnctl;
  logic                    mc_rs_stall;
  logic                    mc_rs_flush_cmplt;

  modport master (
    output mc_rq_vld, mc_rq_cmd, mc_rq_scmd, mc_rq_size, mc_rq_vadr, mc_rq_data,
           mc_rq_rtnctl, mc_rq_flush, mc_rs_stall,
    input  mc_rq_stall, mc_rs_vld, mc_rs_cmd, mc_rs_scmd, mc_rs_data, mc_rs_rtnctl,
           mc_rs_flush_cmplt
  );

  modport slave (
    input  mc_rq_vld, mc_rq_cmd, mc_rq_scmd, mc_rq_size, mc_rq_vadr, mc_rq_data,
           mc_rq_rtnctl, mc_rq_flush, mc_rs_stall,
    output mc_rq_stall, mc_rs_vld, mc_rs_cmd, mc_rs_scmd, mc_rs_data, mc_rs_rtnctl,
           mc_rs_flush_cmplt
  );
endinterface

// File: rtl/mc_resp_model.sv
// Behavioural memory-controller responder: request FIFO, dword backing store, in-order responses,
// write-flush tracking. Define MC_RESP_MODEL_STALL_INJ_EN to add LFSR-driven random stall.
module mc_resp_model #(
  parameter int unsigned RTNCTL_WIDTH = 32,
  parameter int unsigned MEM_AW       = 8,
  parameter int unsigned FIFO_DEPTH   = 8
) (
  input  logic             clk,
  input  logic             i_reset_n,
  mc_resp_model_if.slave   bus,
  output logic [1:0]       o_err
);
  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam int unsigned OutW = PtrW + 2;

  typedef struct packed {
    logic                    is_wr;
    logic [7:0]              be;
    logic [MEM_AW-1:0]       idx;
    logic [63:0]             data;
    logic [RTNCTL_WIDTH-1:0] rtnctl;
  } req_t;

  typedef enum logic [1:0] {StIdle, StWait, StDone} flush_st_e;

  req_t                    fifo_q [FIFO_DEPTH];
  logic [63:0]             mem [2**MEM_AW];
  logic [PtrW-1:0]         wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]         count_q, count_d;
  logic [OutW-1:0]         outst_q, outst_d, flush_cnt_q, flush_cnt_d;
  flush_st_e               flush_st_q, flush_st_d;
  logic                    stall_q, flush_cmplt;
  logic [1:0]              err_q;
  logic                    rs_vld_q;
  logic [2:0]              rs_cmd_q;
  logic [63:0]             rs_data_q;
  logic [RTNCTL_WIDTH-1:0] rs_rtnctl_q;
  logic                    cmd_legal, fifo_full, push, pop, rs_consume, wr_consume;
  logic [7:0]              be_in;
  req_t                    req_in, head;
  logic                    unused_rq;

  assign unused_rq = ^{bus.mc_rq_scmd, bus.mc_rq_vadr[47:MEM_AW+3]};

  always_comb begin
    case (bus.mc_rq_size)
      2'd0:    be_in = 8'h01 << bus.mc_rq_vadr[2:0];
      2'd1:    be_in = 8'h03 << bus.mc_rq_vadr[2:0];
      2'd2:    be_in = 8'h0f << bus.mc_rq_vadr[2:0];
      default: be_in = 8'hff;
    endcase
  end

  assign req_in = '{is_wr:  (bus.mc_rq_cmd == 3'd2),
                    be:     be_in,
                    idx:    bus.mc_rq_vadr[MEM_AW+2:3],
                    data:   bus.mc_rq_data,
                    rtnctl: bus.mc_rq_rtnctl};

  assign cmd_legal  = (bus.mc_rq_cmd == 3'd1) || (bus.mc_rq_cmd == 3'd2);
  assign fifo_full  = (count_q == CntW'(FIFO_DEPTH));
  assign push       = bus.mc_rq_vld && cmd_legal && !fifo_full;
  assign rs_consume = rs_vld_q && !bus.mc_rs_stall;
  assign pop        = (count_q != '0) && (!rs_vld_q || !bus.mc_rs_stall);
  assign wr_consume = rs_consume && (rs_cmd_q == 3'd3);
  assign head       = fifo_q[rd_ptr_q];
  assign count_d    = count_q + CntW'(push) - CntW'(pop);
  assign outst_d    = outst_q + OutW'(push && req_in.is_wr) - OutW'(wr_consume);

  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q] <= req_in;
  end

  // The store is updated as a write leaves the FIFO, so any younger read popped later sees it.
  always_ff @(posedge clk) begin
    if (pop && head.is_wr) begin
      for (int b = 0; b < 8; b++) begin
        if (head.be[b]) mem[head.idx][8*b +: 8] <= head.data[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      outst_q     <= '0;
      stall_q     <= 1'b0;
      err_q       <= '0;
      rs_vld_q    <= 1'b0;
      rs_cmd_q    <= '0;
      rs_data_q   <= '0;
      rs_rtnctl_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      count_q <= count_d;
      outst_q <= outst_d;
      stall_q <= (count_d >= CntW'(FIFO_DEPTH - 2));
      err_q   <= err_q | {bus.mc_rq_vld && cmd_legal && fifo_full,
                          bus.mc_rq_vld && !cmd_legal};
      if (pop) begin
        rs_vld_q    <= 1'b1;
        rs_cmd_q    <= head.is_wr ? 3'd3 : 3'd2;
        rs_data_q   <= head.is_wr ? 64'd0 : mem[head.idx];
        rs_rtnctl_q <= head.rtnctl;
      end else if (rs_consume) begin
        rs_vld_q <= 1'b0;
      end
    end
  end

  // Flush FSM: flush_cnt counts the still-unconsumed writes a pending flush waits on.
  always_ff @(posedge clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      flush_st_q  <= StIdle;
      flush_cnt_q <= '0;
    end else begin
      flush_st_q  <= flush_st_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  always_comb begin
    flush_st_d  = flush_st_q;
    flush_cnt_d = flush_cnt_q;
    if (wr_consume && (flush_cnt_q != '0)) flush_cnt_d = flush_cnt_q - OutW'(1);
    case (flush_st_q)
      StIdle: begin
        if (bus.mc_rq_flush) begin
          flush_cnt_d = outst_d;
          flush_st_d  = (outst_d == '0) ? StDone : StWait;
        end
      end
      StWait: begin
        if (bus.mc_rq_flush) flush_cnt_d = outst_d;
        if (flush_cnt_d == '0) flush_st_d = StDone;
      end
      StDone: begin
        // A flush landing on the pulse cycle is absorbed unless it covers new writes.
        if (bus.mc_rq_flush && (outst_d != '0)) begin
          flush_cnt_d = outst_d;
          flush_st_d  = StWait;
        end else begin
          flush_st_d = StIdle;
        end
      end
      default: flush_st_d = StIdle;
    endcase
  end

  always_comb begin
    flush_cmplt = 1'b0;
    if (flush_st_q == StDone) flush_cmplt = 1'b1;
  end

`ifdef MC_RESP_MODEL_STALL_INJ_EN
  logic [15:0] lfsr_q;

  always_ff @(posedge clk or negedge i_reset_n) begin
    if (!i_reset_n) lfsr_q <= 16'hace1;
    else            lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  end

  assign bus.mc_rq_stall = stall_q || (lfsr_q[1:0] == 2'b00);
`else
  assign bus.mc_rq_stall = stall_q;
`endif

  assign bus.mc_rs_vld         = rs_vld_q;
  assign bus.mc_rs_cmd         = rs_cmd_q;
  assign bus.mc_rs_scmd        = 4'd0;
  assign bus.mc_rs_data        = rs_data_q;
  assign bus.mc_rs_rtnctl      = rs_rtnctl_q;
  assign bus.mc_rs_flush_cmplt = flush_cmplt;
  assign o_err                 = err_q;
endmodule
